// File: rtl/pri_enc_arb_pkg.sv
// -----------------------------------------------------------------------------
// pri_enc_pkg
// Shared definitions for the pri_enc_arb block: the arbiter FSM state type and
// the upper bound on the number of request lines.
// No ports (package).
// -----------------------------------------------------------------------------
package pri_enc_pkg;

    // Largest request vector the arbiter is built for.
    localparam int PRI_ENC_MAX_N = 64;

    // IDLE samples requests every cycle; HOLD freezes the grant until accepted.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage : pri_enc_pkg

// File: rtl/pri_enc_arb_core.sv
// -----------------------------------------------------------------------------
// pri_enc_core
// Combinational highest-set-bit finder over an N-bit vector.
// Ports:
//   vec_i  [N-1:0]  input vector to search
//   idx_o  [W-1:0]  index of the highest set bit (0 when none set)
//   any_o           at least one bit of vec_i is set
// -----------------------------------------------------------------------------
module pri_enc_core #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        // Ascending scan: the last hit, i.e. the highest set bit, wins.
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

endmodule : pri_enc_core

// File: rtl/pri_enc_arb.sv
// -----------------------------------------------------------------------------
// pri_enc_arb
// Registered priority arbiter. In IDLE it samples req every cycle and, if any
// line is set, registers the winner and moves to HOLD. The grant stays frozen
// in HOLD (req ignored) until gnt_ready accepts it; the FSM then spends at
// least one cycle in IDLE before the next grant.
//
// Configuration macro: PRI_ENC_ARB_RR_EN
//   undefined : fixed priority, bit N-1 highest.
//   defined   : round-robin; a pointer takes the accepted index and the next
//               search starts at ptr-1 going downward, wrapping modulo N, with
//               ptr itself checked last.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset
//   req        [N-1:0]   request vector
//   gnt_ready            consumer accepts the grant when gnt_valid is high
//   gnt_valid            grant registers hold a winner
//   gnt_idx    [W-1:0]   winner index, 0 when !gnt_valid
//   gnt_onehot [N-1:0]   one-hot winner, 0 when !gnt_valid
//   none                 last IDLE sample saw no request
// -----------------------------------------------------------------------------
module pri_enc_arb
    import pri_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         gnt_ready,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot,
    output logic         none
);

    if (N < 2 || N > PRI_ENC_MAX_N) begin : g_bad_n
        $error("pri_enc_arb: N must be in 2..%0d", PRI_ENC_MAX_N);
    end

    state_t       state_q;
    logic         gnt_valid_q;
    logic [W-1:0] gnt_idx_q;
    logic [N-1:0] gnt_onehot_q;
    logic         none_q;

    logic [N-1:0] srch_vec;
    logic [W-1:0] core_idx;
    logic         srch_any;
    logic [W-1:0] gnt_idx_d;
    logic [N-1:0] gnt_onehot_d;

`ifdef PRI_ENC_ARB_RR_EN
    localparam logic [W:0] N_EXT = (W+1)'(N);

    logic [W-1:0]   ptr_q;
    logic [2*N-1:0] req_dbl;
    logic [W:0]     idx_sum;

    // Rotating right by ptr maps search slot j to request (j+ptr) mod N, so the
    // top slot is request ptr-1 and slot 0 (lowest priority) is request ptr.
    // ptr < N always, so shifting the doubled vector gives the wrap for free.
    always_comb begin
        req_dbl  = {req, req} >> ptr_q;
        srch_vec = req_dbl[N-1:0];
    end

    // Undo the rotation; the sum is below 2N, so one conditional subtract is
    // an exact modulo N even when N is not a power of two.
    always_comb begin
        idx_sum = {1'b0, core_idx} + {1'b0, ptr_q};
        if (idx_sum >= N_EXT) begin
            idx_sum = idx_sum - N_EXT;
        end
        gnt_idx_d = idx_sum[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (gnt_valid_q && gnt_ready) begin
            ptr_q <= gnt_idx_q;
        end
    end
`else
    always_comb begin
        srch_vec  = req;
        gnt_idx_d = core_idx;
    end
`endif

    pri_enc_core #(
        .N (N)
    ) u_core (
        .vec_i (srch_vec),
        .idx_o (core_idx),
        .any_o (srch_any)
    );

    always_comb begin
        gnt_onehot_d = {{(N-1){1'b0}}, 1'b1} << gnt_idx_d;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // updates from the values present before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            none_q       <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (srch_any) begin
                        gnt_valid_q  <= 1'b1;
                        gnt_idx_q    <= gnt_idx_d;
                        gnt_onehot_q <= gnt_onehot_d;
                        none_q       <= 1'b0;
                        state_q      <= ST_HOLD;
                    end else begin
                        gnt_valid_q  <= 1'b0;
                        gnt_idx_q    <= '0;
                        gnt_onehot_q <= '0;
                        none_q       <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // none keeps its value: it reflects the last IDLE sample.
                    if (gnt_ready) begin
                        gnt_valid_q  <= 1'b0;
                        gnt_idx_q    <= '0;
                        gnt_onehot_q <= '0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;
    assign none       = none_q;

endmodule : pri_enc_arb

// File: tb/tb_pri_enc_arb.sv
// -----------------------------------------------------------------------------
// tb_pri_enc_arb
// Scoreboard bench for pri_enc_arb. Two instances: N=8 and N=5 (non power of
// two). The driver applies one directed vector per cycle and pushes the
// hand-computed output expected after that edge; a monitor pops and compares
// on the falling edge. Expected indices depend on PRI_ENC_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_pri_enc_arb;

`ifdef PRI_ENC_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        string      name;
        bit         sel5;
        bit         valid;
        logic [2:0] idx;
        logic [7:0] onehot;
        bit         none;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req8;
    logic       rdy8;
    logic [4:0] req5;
    logic       rdy5;

    logic       valid8, none8, valid5, none5;
    logic [2:0] idx8, idx5;
    logic [7:0] oh8;
    logic [4:0] oh5;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pri_enc_arb #(.N(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .req        (req8),
        .gnt_ready  (rdy8),
        .gnt_valid  (valid8),
        .gnt_idx    (idx8),
        .gnt_onehot (oh8),
        .none       (none8)
    );

    pri_enc_arb #(.N(5)) u_dut5 (
        .clk        (clk),
        .rst        (rst),
        .req        (req5),
        .gnt_ready  (rdy5),
        .gnt_valid  (valid5),
        .gnt_idx    (idx5),
        .gnt_onehot (oh5),
        .none       (none5)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel5) begin
                    check({e.name, ".valid"},  16'(valid5), 16'(e.valid));
                    check({e.name, ".idx"},    16'(idx5),   16'(e.idx));
                    check({e.name, ".onehot"}, 16'(oh5),    16'(e.onehot));
                    check({e.name, ".none"},   16'(none5),  16'(e.none));
                end else begin
                    check({e.name, ".valid"},  16'(valid8), 16'(e.valid));
                    check({e.name, ".idx"},    16'(idx8),   16'(e.idx));
                    check({e.name, ".onehot"}, 16'(oh8),    16'(e.onehot));
                    check({e.name, ".none"},   16'(none8),  16'(e.none));
                end
            end
        end
    end

    // Drive one vector, let the edge sample it, and queue the expected result.
    task automatic apply(input string name, input bit sel5, input bit r,
                         input logic [7:0] rq, input bit rd,
                         input bit ev, input int eidx, input bit en);
        exp_t e;
        rst = r;
        if (sel5) begin
            req5 = rq[4:0]; rdy5 = rd; req8 = '0; rdy8 = 1'b0;
        end else begin
            req8 = rq; rdy8 = rd; req5 = '0; rdy5 = 1'b0;
        end
        @(posedge clk);
        e.name   = name;
        e.sel5   = sel5;
        e.valid  = ev;
        e.idx    = 3'(eidx);
        e.onehot = ev ? (8'd1 << eidx) : 8'd0;
        e.none   = en;
        sb.push_back(e);
        #1;
    endtask

    initial begin
        rst = 1'b1; req8 = '0; rdy8 = 1'b0; req5 = '0; rdy5 = 1'b0;

        //     name          sel5 rst req    rdy  valid idx none
        apply("reset0",      0,   1,  8'h00, 0,   0,    0,  1);
        apply("reset1",      0,   1,  8'h00, 0,   0,    0,  1);
        apply("idle0",       0,   0,  8'h00, 0,   0,    0,  1);
        apply("idle1",       0,   0,  8'h00, 0,   0,    0,  1);
        apply("idle2",       0,   0,  8'h00, 0,   0,    0,  1);
        // Multi-bit request, grant held while not ready and while req changes.
        apply("grant29",     0,   0,  8'h29, 0,   1,    5,  0);
        apply("hold29_a",    0,   0,  8'h29, 0,   1,    5,  0);
        apply("hold29_b",    0,   0,  8'h29, 0,   1,    5,  0);
        apply("hold29_c",    0,   0,  8'h29, 0,   1,    5,  0);
        apply("hold_req01",  0,   0,  8'h01, 0,   1,    5,  0);
        apply("accept5",     0,   0,  8'h01, 1,   0,    0,  0);
        apply("grant01",     0,   0,  8'h01, 0,   1,    0,  0);
        apply("accept0",     0,   0,  8'h00, 1,   0,    0,  0);
        apply("idle_none",   0,   0,  8'h00, 0,   0,    0,  1);
        // Withdrawal of the granted request while in HOLD.
        apply("grant81",     0,   0,  8'h81, 0,   1,    7,  0);
        apply("withdraw_a",  0,   0,  8'h00, 0,   1,    7,  0);
        apply("withdraw_b",  0,   0,  8'h00, 0,   1,    7,  0);
        apply("accept7",     0,   0,  8'h00, 1,   0,    0,  0);
        apply("rdy_no_vld",  0,   0,  8'h00, 1,   0,    0,  1);
        // Reset mid-HOLD, with ready asserted in the same cycle.
        apply("grant0c",     0,   0,  8'h0C, 0,   1,    3,  0);
        apply("rst_hold",    0,   1,  8'h0C, 1,   0,    0,  1);
        apply("post_rst",    0,   0,  8'h00, 0,   0,    0,  1);
        // Boundary single bits and the all-ones vector.
        apply("grantff",     0,   0,  8'hFF, 0,   1,    7,  0);
        apply("acceptff",    0,   0,  8'hFF, 1,   0,    0,  0);
        apply("grant02",     0,   0,  8'h02, 1,   1,    1,  0);
        apply("accept02",    0,   0,  8'h02, 1,   0,    0,  0);
        apply("grant40",     0,   0,  8'h40, 1,   1,    6,  0);
        apply("accept40",    0,   0,  8'h00, 1,   0,    0,  0);
        apply("idle_end",    0,   0,  8'h00, 0,   0,    0,  1);

        // All requesters contend, consumer always ready: fixed priority keeps
        // granting 7; round-robin walks 7,6,...,0,7.
        apply("ff_reset",    0,   1,  8'hFF, 1,   0,    0,  1);
        for (int k = 0; k < 9; k++) begin
            apply($sformatf("ff_grant%0d", k), 0, 0, 8'hFF, 1, 1,
                  RR ? (15 - k) % 8 : 7, 0);
            apply($sformatf("ff_acc%0d", k),   0, 0, 8'hFF, 1, 0, 0, 0);
        end

        // N=5 instance: req=5'b10001; round-robin alternates 4,0,4.
        apply("n5_reset",    1,   1,  8'h00, 0,   0,    0,  1);
        apply("n5_grant_a",  1,   0,  8'h11, 0,   1,    4,  0);
        apply("n5_acc_a",    1,   0,  8'h11, 1,   0,    0,  0);
        apply("n5_grant_b",  1,   0,  8'h11, 1,   1,    RR ? 0 : 4, 0);
        apply("n5_acc_b",    1,   0,  8'h11, 1,   0,    0,  0);
        apply("n5_grant_c",  1,   0,  8'h11, 1,   1,    4,  0);
        apply("n5_acc_c",    1,   0,  8'h00, 1,   0,    0,  0);
        apply("n5_idle",     1,   0,  8'h00, 0,   0,    0,  1);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        check("scoreboard_drain", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pri_enc_arb
